// File: rtl/tensor_core_register_loader.sv
// Streams signed bytes from an upstream valid/ready source into consecutive
// registers of a tensor-core register file, wrapping addresses modulo the depth.
module tensor_core_register_loader #(
  parameter  int unsigned NUMBER_OF_REGISTERS = 32,
  localparam int unsigned AW = $clog2(NUMBER_OF_REGISTERS),
  localparam int unsigned CW = AW + 1
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  input  logic                 start_in,
  input  logic [AW-1:0]        start_address_in,
  input  logic [CW-1:0]        count_in,
  input  logic                 abort_in,
  input  logic                 data_valid_in,
  input  logic signed [7:0]    data_in,
  output logic                 data_ready_out,
  output logic                 write_enable_out,
  output logic [AW-1:0]        write_register_address_out,
  output logic signed [7:0]    write_data_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 error_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_ptr;
  logic [CW-1:0]   r_remaining;

  logic            w_count_ok;
  logic            w_handshake;
  logic            w_last;
  logic [AW-1:0]   w_ptr_next;

  assign w_count_ok  = (count_in != '0) && (count_in <= CW'(NUMBER_OF_REGISTERS));
  assign w_handshake = (r_state == S_LOAD) && !abort_in && data_valid_in;
  assign w_last      = (r_remaining == CW'(1));
  // Explicit wrap so non-power-of-two depths stay inside the register file.
  assign w_ptr_next  = (r_ptr == AW'(NUMBER_OF_REGISTERS - 1)) ? '0 : r_ptr + AW'(1);

  assign data_ready_out = (r_state == S_LOAD) && !abort_in;
  assign busy_out       = (r_state != S_IDLE);

  // Burst FSM with registered write port and status pulses.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_state                    <= S_IDLE;
      r_ptr                      <= '0;
      r_remaining                <= '0;
      write_enable_out           <= 1'b0;
      write_register_address_out <= '0;
      write_data_out             <= '0;
      done_out                   <= 1'b0;
      error_out                  <= 1'b0;
    end else begin
      write_enable_out <= 1'b0;
      done_out         <= 1'b0;
      error_out        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            if (w_count_ok) begin
              r_ptr       <= start_address_in;
              r_remaining <= count_in;
              r_state     <= S_LOAD;
            end else begin
              error_out <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (abort_in) begin
            r_state <= S_IDLE;
          end else if (w_handshake) begin
            write_enable_out           <= 1'b1;
            write_register_address_out <= r_ptr;
            write_data_out             <= data_in;
            r_ptr                      <= w_ptr_next;
            r_remaining                <= r_remaining - CW'(1);
            if (w_last) begin
              r_state  <= S_DONE;
              done_out <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_core_register_loader.sv
// Randomized and directed bench for tensor_core_register_loader against a
// burst-level reference model.
module tb_tensor_core_register_loader;

  localparam int N  = 32;
  localparam int AW = 5;
  localparam int CW = 6;

  logic                clock_in;
  logic                reset_in;
  logic                start_in;
  logic [AW-1:0]       start_address_in;
  logic [CW-1:0]       count_in;
  logic                abort_in;
  logic                data_valid_in;
  logic signed [7:0]   data_in;
  logic                data_ready_out;
  logic                write_enable_out;
  logic [AW-1:0]       write_register_address_out;
  logic signed [7:0]   write_data_out;
  logic                busy_out;
  logic                done_out;
  logic                error_out;

  tensor_core_register_loader #(.NUMBER_OF_REGISTERS(N)) dut (
    .clock_in                   (clock_in),
    .reset_in                   (reset_in),
    .start_in                   (start_in),
    .start_address_in           (start_address_in),
    .count_in                   (count_in),
    .abort_in                   (abort_in),
    .data_valid_in              (data_valid_in),
    .data_in                    (data_in),
    .data_ready_out             (data_ready_out),
    .write_enable_out           (write_enable_out),
    .write_register_address_out (write_register_address_out),
    .write_data_out             (write_data_out),
    .busy_out                   (busy_out),
    .done_out                   (done_out),
    .error_out                  (error_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a burst is "active" until its final cycle has elapsed.
  bit m_active, m_fin;
  int m_ptr, m_left;
  int exp_we, exp_addr, exp_data, exp_done, exp_err;

  // Observation log of DUT writes and pulses.
  int log_addr[$];
  int log_data[$];
  int n_done, n_errp, done_widx;

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      m_active <= 1'b0; m_fin <= 1'b0; m_ptr <= 0; m_left <= 0;
      exp_we <= 0; exp_addr <= 0; exp_data <= 0; exp_done <= 0; exp_err <= 0;
    end else begin
      exp_we <= 0; exp_done <= 0; exp_err <= 0;
      if (m_fin) begin
        m_fin    <= 1'b0;
        m_active <= 1'b0;
      end else if (m_active) begin
        if (abort_in) begin
          m_active <= 1'b0;
        end else if (data_valid_in) begin
          exp_we   <= 1;
          exp_addr <= m_ptr;
          exp_data <= int'($unsigned(data_in));
          m_ptr    <= (m_ptr + 1) % N;
          m_left   <= m_left - 1;
          if (m_left == 1) begin
            m_fin    <= 1'b1;
            exp_done <= 1;
          end
        end
      end else if (start_in) begin
        if (int'(count_in) >= 1 && int'(count_in) <= N) begin
          m_active <= 1'b1;
          m_ptr    <= int'(start_address_in);
          m_left   <= int'(count_in);
        end else begin
          exp_err <= 1;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clock_in) begin
    chk("write_enable", int'(write_enable_out), exp_we);
    chk("write_addr", int'(write_register_address_out), exp_addr);
    chk("write_data", int'($unsigned(write_data_out)), exp_data);
    chk("done", int'(done_out), exp_done);
    chk("error", int'(error_out), exp_err);
    chk("busy", int'(busy_out), int'(m_active));
    chk("ready", int'(data_ready_out), int'(m_active && !m_fin && !abort_in));
    if (write_enable_out) begin
      log_addr.push_back(int'(write_register_address_out));
      log_data.push_back(int'($unsigned(write_data_out)));
    end
    if (done_out) begin
      n_done++;
      done_widx = log_addr.size();
    end
    if (error_out) n_errp++;
  end

  task automatic step();
    @(posedge clock_in);
    #2;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    n_done = 0;
    n_errp = 0;
    done_widx = -1;
  endtask

  task automatic start_burst(input int a, input int c);
    start_in = 1'b1;
    start_address_in = AW'(a);
    count_in = CW'(c);
    step();
    start_in = 1'b0;
  endtask

  task automatic feed(input int b);
    data_valid_in = 1'b1;
    data_in = 8'(b);
    step();
    data_valid_in = 1'b0;
  endtask

  task automatic chk_write(input string name, input int idx, input int a, input int d);
    if (idx < log_addr.size()) begin
      chk({name, "_addr"}, log_addr[idx], a);
      chk({name, "_data"}, log_data[idx], d);
    end else begin
      chk({name, "_missing"}, log_addr.size(), idx + 1);
    end
  endtask

  initial begin
    reset_in = 1'b1;
    start_in = 1'b0;
    start_address_in = '0;
    count_in = '0;
    abort_in = 1'b0;
    data_valid_in = 1'b0;
    data_in = '0;
    clear_log();
    repeat (2) @(posedge clock_in);
    #1;
    chk("rst_we", int'(write_enable_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_ready", int'(data_ready_out), 0);
    chk("rst_addr", int'(write_register_address_out), 0);
    step();
    reset_in = 1'b0;

    // Burst of 16 from address 0, accepted on the first edge after reset.
    clear_log();
    start_burst(0, 16);
    for (int i = 1; i <= 16; i++) feed(i);
    repeat (3) step();
    chk("s1_count", log_addr.size(), 16);
    for (int i = 0; i < 16; i++) chk_write("s1", i, i, i + 1);
    chk("s1_done_cnt", n_done, 1);
    chk("s1_done_at", done_widx, 16);

    // Address wrap with negative bytes.
    clear_log();
    start_burst(30, 4);
    for (int i = 1; i <= 4; i++) feed(-i);
    repeat (3) step();
    chk("s2_count", log_addr.size(), 4);
    chk_write("s2_0", 0, 30, 255);
    chk_write("s2_1", 1, 31, 254);
    chk_write("s2_2", 2, 0, 253);
    chk_write("s2_3", 3, 1, 252);

    // Valid toggling every other cycle.
    clear_log();
    start_burst(7, 4);
    for (int i = 0; i < 4; i++) begin
      feed(8'h40 + i);
      chk("s3_busy", int'(busy_out), 1);
      step();
    end
    repeat (2) step();
    chk("s3_count", log_addr.size(), 4);
    chk_write("s3_last", 3, 10, 8'h43);
    chk("s3_done_cnt", n_done, 1);

    // Rejected starts.
    clear_log();
    start_burst(3, 0);
    chk("s4_err0", int'(error_out), 1);
    chk("s4_busy0", int'(busy_out), 0);
    step();
    start_burst(3, 33);
    chk("s4_err33", int'(error_out), 1);
    chk("s4_busy33", int'(busy_out), 0);
    repeat (2) step();
    chk("s4_err_cnt", n_errp, 2);
    chk("s4_writes", log_addr.size(), 0);

    // Abort after two bytes, then a fresh burst.
    clear_log();
    start_burst(5, 8);
    feed(8'h11);
    feed(8'h22);
    abort_in = 1'b1;
    data_valid_in = 1'b1;
    data_in = 8'h33;
    #1;
    chk("s5_ready_blocked", int'(data_ready_out), 0);
    step();
    abort_in = 1'b0;
    data_valid_in = 1'b0;
    chk("s5_busy_drop", int'(busy_out), 0);
    repeat (2) step();
    chk("s5_count", log_addr.size(), 2);
    chk_write("s5_w1", 1, 6, 8'h22);
    chk("s5_no_done", n_done, 0);
    start_burst(3, 1);
    feed(8'h55);
    repeat (2) step();
    chk_write("s5_new", 2, 3, 8'h55);
    chk("s5_new_done", n_done, 1);

    // Asynchronous reset mid-burst.
    clear_log();
    start_burst(10, 8);
    for (int i = 1; i <= 3; i++) feed(i);
    data_valid_in = 1'b1;
    data_in = 8'h77;
    @(negedge clock_in);
    #2;
    reset_in = 1'b1;
    #1;
    chk("s6_we", int'(write_enable_out), 0);
    chk("s6_addr", int'(write_register_address_out), 0);
    chk("s6_data", int'($unsigned(write_data_out)), 0);
    chk("s6_busy", int'(busy_out), 0);
    chk("s6_ready", int'(data_ready_out), 0);
    chk("s6_done", int'(done_out), 0);
    step();
    reset_in = 1'b0;
    repeat (3) step();
    data_valid_in = 1'b0;
    chk("s6_count", log_addr.size(), 3);
    chk("s6_no_done", n_done, 0);

    // Start held across reset release is taken on the first edge.
    clear_log();
    reset_in = 1'b1;
    start_in = 1'b1;
    start_address_in = AW'(4);
    count_in = CW'(2);
    step();
    #3;
    reset_in = 1'b0;
    step();
    start_in = 1'b0;
    feed(9);
    feed(10);
    repeat (2) step();
    chk("s7_count", log_addr.size(), 2);
    chk_write("s7_w0", 0, 4, 9);
    chk_write("s7_w1", 1, 5, 10);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      start_in = ($urandom_range(0, 3) == 0);
      start_address_in = AW'($urandom_range(0, N - 1));
      count_in = CW'($urandom_range(0, 34));
      abort_in = ($urandom_range(0, 11) == 0);
      data_valid_in = ($urandom_range(0, 2) != 0);
      data_in = 8'($urandom);
      step();
    end
    start_in = 1'b0;
    abort_in = 1'b0;
    data_valid_in = 1'b0;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
